// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM pins.
// The slave side is the arbiter; the master side drives requests and returns ram_in.
interface ram_arbiter_if #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16
);
  logic              req_a;
  logic              rw_a;
  logic [ADR_W-1:0]  adr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              rw_b;
  logic [ADR_W-1:0]  adr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  logic              ram_enable;
  logic              ram_rw;
  logic [ADR_W-1:0]  ram_adr;
  logic [DATA_W-1:0] ram_out;
  logic [DATA_W-1:0] ram_in;

  modport slave (
    input  req_a, rw_a, adr_a, wdata_a,
    input  req_b, rw_b, adr_b, wdata_b,
    input  ram_in,
    output ack_a, rdata_a, ack_b, rdata_b,
    output ram_enable, ram_rw, ram_adr, ram_out
  );

  modport master (
    output req_a, rw_a, adr_a, wdata_a,
    output req_b, rw_b, adr_b, wdata_b,
    output ram_in,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  ram_enable, ram_rw, ram_adr, ram_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared 64x16 RAM: boot loader (A) vs core (B).
// Optional macro RAM_ARB_ROUND_ROBIN_EN alternates simultaneous grants; default is A-priority.
module ram_arbiter #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         boot,
  ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, DONE_A, ISSUE_B, DONE_B} state_e;

  state_e            state_q, state_d;
  logic              grant_a, grant_b, pick_a;
  logic [ADR_W-1:0]  adr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant_b_q;  // 1 = port B was served last
`endif

  // Tie-break between simultaneous requests; boot always forces A.
  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    pick_a = last_grant_b_q;
`else
    pick_a = 1'b1;
`endif
    grant_a = (state_q == IDLE) && bus.req_a && (boot || !bus.req_b || pick_a);
    grant_b = (state_q == IDLE) && bus.req_b && !boot && (!bus.req_a || !pick_a);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q <= IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_a)      state_d = ISSUE_A;
        else if (grant_b) state_d = ISSUE_B;
      end
      ISSUE_A: state_d = DONE_A;
      DONE_A:  state_d = IDLE;
      ISSUE_B: state_d = DONE_B;
      DONE_B:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access registers are captured at grant; read data is captured at the end of DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q     <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_grant_b_q <= 1'b1;
`endif
    end else if (ce) begin
      if (grant_a) begin
        adr_q   <= bus.adr_a;
        rw_q    <= bus.rw_a;
        wdata_q <= bus.wdata_a;
      end else if (grant_b) begin
        adr_q   <= bus.adr_b;
        rw_q    <= bus.rw_b;
        wdata_q <= bus.wdata_b;
      end
      if (state_q == DONE_A && !rw_q) rdata_a_q <= bus.ram_in;
      if (state_q == DONE_B && !rw_q) rdata_b_q <= bus.ram_in;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (state_q == DONE_A) last_grant_b_q <= 1'b0;
      if (state_q == DONE_B) last_grant_b_q <= 1'b1;
`endif
    end
  end

  logic issue;
  assign issue = (state_q == ISSUE_A) || (state_q == ISSUE_B);

  assign bus.ram_enable = issue;
  assign bus.ram_rw     = issue && rw_q;
  assign bus.ram_adr    = adr_q;
  assign bus.ram_out    = wdata_q;

  // The synchronous RAM presents data during DONE, so read data bypasses the hold register then.
  assign bus.ack_a   = (state_q == DONE_A);
  assign bus.ack_b   = (state_q == DONE_B);
  assign bus.rdata_a = (state_q == DONE_A && !rw_q) ? bus.ram_in : rdata_a_q;
  assign bus.rdata_b = (state_q == DONE_B && !rw_q) ? bus.ram_in : rdata_b_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous 64x16 RAM.
// Honours RAM_ARB_ROUND_ROBIN_EN for the contention sequence.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst, ce, boot;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] mem [64];

  ram_arbiter_if #(.ADR_W(6), .DATA_W(16)) bus ();

  ram_arbiter #(.ADR_W(6), .DATA_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .boot (boot),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.ram_enable) begin
      if (bus.ram_rw) mem[bus.ram_adr] <= bus.ram_out;
      else            bus.ram_in       <= mem[bus.ram_adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [11:0] a_pat, b_pat;
  int          cnt_a, cnt_b;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 | 16'(i);
    mem[5] = 16'h1234;
    bus.ram_in = '0;
    rst = 1'b1; ce = 1'b1; boot = 1'b0;
    bus.req_a = 0; bus.rw_a = 0; bus.adr_a = '0; bus.wdata_a = '0;
    bus.req_b = 0; bus.rw_b = 0; bus.adr_b = '0; bus.wdata_b = '0;

    // Reset state
    tick(); tick();
    check("rst_en",    32'(bus.ram_enable), 0);
    check("rst_rw",    32'(bus.ram_rw),     0);
    check("rst_adr",   32'(bus.ram_adr),    0);
    check("rst_out",   32'(bus.ram_out),    0);
    check("rst_ack_a", 32'(bus.ack_a),      0);
    check("rst_ack_b", 32'(bus.ack_b),      0);
    check("rst_rd_a",  32'(bus.rdata_a),    0);
    check("rst_rd_b",  32'(bus.rdata_b),    0);
    rst = 1'b0;

    // 1: port B read of 0x05
    bus.req_b = 1; bus.rw_b = 0; bus.adr_b = 6'h05;
    tick();
    check("t1_en",  32'(bus.ram_enable), 1);
    check("t1_adr", 32'(bus.ram_adr),    32'h05);
    check("t1_rw",  32'(bus.ram_rw),     0);
    check("t1_ack_early", 32'(bus.ack_b), 0);
    tick();
    check("t1_ack_b", 32'(bus.ack_b),   1);
    check("t1_rd_b",  32'(bus.rdata_b), 32'h1234);
    check("t1_ack_a", 32'(bus.ack_a),   0);
    bus.req_b = 0;
    tick();
    check("t1_ack_drop", 32'(bus.ack_b),      0);
    check("t1_en_drop",  32'(bus.ram_enable), 0);
    check("t1_rd_hold",  32'(bus.rdata_b),    32'h1234);

    // 2: boot write by A while B is kept waiting
    boot = 1;
    bus.req_a = 1; bus.rw_a = 1; bus.adr_a = 6'h3F; bus.wdata_a = 16'hBEEF;
    bus.req_b = 1; bus.rw_b = 0; bus.adr_b = 6'h07;
    tick();
    check("t2_en",  32'(bus.ram_enable), 1);
    check("t2_rw",  32'(bus.ram_rw),     1);
    check("t2_adr", 32'(bus.ram_adr),    32'h3F);
    check("t2_out", 32'(bus.ram_out),    32'hBEEF);
    tick();
    check("t2_ack_a", 32'(bus.ack_a), 1);
    check("t2_ack_b", 32'(bus.ack_b), 0);
    bus.req_a = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt_a += int'(bus.ack_a);
      cnt_b += int'(bus.ack_b);
    end
    check("t2_no_ack_b_boot", 32'(cnt_b), 0);
    check("t2_single_ack_a",  32'(cnt_a), 0);
    check("t2_mem_written",   32'(mem[63]), 32'hBEEF);
    boot = 0;
    tick();
    check("t2_b_en",  32'(bus.ram_enable), 1);
    check("t2_b_adr", 32'(bus.ram_adr),    32'h07);
    tick();
    check("t2_b_ack", 32'(bus.ack_b),   1);
    check("t2_b_rd",  32'(bus.rdata_b), 32'hA007);
    bus.req_b = 0;
    tick();

    // 3: continuous contention
    bus.req_a = 1; bus.rw_a = 0; bus.adr_a = 6'h02;
    bus.req_b = 1; bus.rw_b = 0; bus.adr_b = 6'h03;
    for (int i = 0; i < 12; i++) begin
      tick();
      a_pat[i] = bus.ack_a;
      b_pat[i] = bus.ack_b;
    end
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check("t3_pat_a", 32'(a_pat), 32'h082);
    check("t3_pat_b", 32'(b_pat), 32'h410);
`else
    check("t3_pat_a", 32'(a_pat), 32'h492);
    check("t3_pat_b", 32'(b_pat), 32'h000);
`endif
    check("t3_rd_a", 32'(bus.rdata_a), 32'hA002);
    bus.req_a = 0; bus.req_b = 0;
    tick();

    // 4: ce low while in ISSUE_A
    bus.req_a = 1; bus.rw_a = 0; bus.adr_a = 6'h10;
    tick();
    check("t4_en", 32'(bus.ram_enable), 1);
    ce = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt_a += int'(bus.ack_a);
      cnt_b += int'(bus.ram_enable);
    end
    check("t4_no_ack_hold", 32'(cnt_a), 0);
    check("t4_en_hold",     32'(cnt_b), 4);
    ce = 1;
    tick();
    check("t4_ack_a", 32'(bus.ack_a),   1);
    check("t4_rd_a",  32'(bus.rdata_a), 32'hA010);
    bus.req_a = 0;
    tick();

    // 5: reset during ISSUE_B, then a fresh B read
    bus.req_b = 1; bus.rw_b = 0; bus.adr_b = 6'h05;
    tick();
    check("t5_en", 32'(bus.ram_enable), 1);
    rst = 1; bus.req_b = 0;
    tick();
    check("t5_en_clr",  32'(bus.ram_enable), 0);
    check("t5_adr_clr", 32'(bus.ram_adr),    0);
    check("t5_ack_b",   32'(bus.ack_b),      0);
    check("t5_rd_b",    32'(bus.rdata_b),    0);
    check("t5_rd_a",    32'(bus.rdata_a),    0);
    rst = 0;
    tick();
    check("t5_no_late_ack", 32'(bus.ack_b), 0);
    bus.req_b = 1; bus.adr_b = 6'h01;
    tick();
    check("t5_re_en",  32'(bus.ram_enable), 1);
    check("t5_re_adr", 32'(bus.ram_adr),    32'h01);
    tick();
    check("t5_re_ack", 32'(bus.ack_b),   1);
    check("t5_re_rd",  32'(bus.rdata_b), 32'hA001);
    bus.req_b = 0;
    tick();

    // 6: back-to-back A reads with req held through the first ack
    bus.req_a = 1; bus.rw_a = 0; bus.adr_a = 6'h00;
    tick(); tick();
    check("t6_ack0", 32'(bus.ack_a),   1);
    check("t6_rd0",  32'(bus.rdata_a), 32'hA000);
    bus.adr_a = 6'h01;
    tick();
    check("t6_gap",     32'(bus.ack_a),   0);
    check("t6_rd_hold", 32'(bus.rdata_a), 32'hA000);
    tick();
    check("t6_adr1", 32'(bus.ram_adr), 32'h01);
    tick();
    check("t6_ack1", 32'(bus.ack_a),   1);
    check("t6_rd1",  32'(bus.rdata_a), 32'hA001);
    bus.req_a = 0;
    tick();
    check("t6_idle", 32'(bus.ack_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
